// File: rtl/psram_dev_pkg.sv
// Shared types and constants for the QSPI PSRAM device model.
package psram_dev_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddr,
    StWait,
    StRdata,
    StWdata,
    StSkip
  } state_e;

  localparam logic [7:0] CMD_QREAD  = 8'hEB;
  localparam logic [7:0] CMD_QWRITE = 8'h38;
  localparam logic [7:0] CMD_QPI_EN = 8'h35;
  localparam logic [7:0] CMD_QPI_EX = 8'hF5;

  localparam int unsigned ADDR_NIBBLES = 6;

endpackage

// File: rtl/psram_sck_sync.sv
// Registers the QSPI pins into the clock domain and detects sck edges.
module psram_sck_sync (
  input  logic       clock,
  input  logic       reset,
  input  logic       sck_i,
  input  logic       ce_n_i,
  input  logic [3:0] dio_i,
  output logic       ce_n_o,
  output logic [3:0] dio_o,
  output logic       rise_o,
  output logic       fall_o
);

  logic       sck_q, sck_qq;
  logic       ce_n_q;
  logic [3:0] dio_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sck_q  <= 1'b0;
      sck_qq <= 1'b0;
      ce_n_q <= 1'b1;
      dio_q  <= 4'h0;
    end else begin
      sck_q  <= sck_i;
      sck_qq <= sck_q;
      ce_n_q <= ce_n_i;
      dio_q  <= dio_i;
    end
  end

  assign ce_n_o = ce_n_q;
  assign dio_o  = dio_q;
  assign rise_o = sck_q & ~sck_qq;
  assign fall_o = ~sck_q & sck_qq;

endmodule

// File: rtl/psram_qspi_dev.sv
// QSPI/QPI PSRAM device: command/address/data FSM over an internal byte array.
module psram_qspi_dev
  import psram_dev_pkg::*;
#(
  parameter int unsigned ADDR_W   = 22,
  parameter int unsigned WAIT_CYC = 6
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       qspi_sck,
  input  logic       qspi_ce_n,
  input  logic [3:0] dio_in,
  output logic [3:0] dio_out,
  output logic [3:0] dio_oe,
  output logic       qpi
);

  localparam logic [7:0] WaitLast = 8'(WAIT_CYC - 1);
  localparam logic [7:0] AddrLast = 8'(ADDR_NIBBLES - 1);

  logic       ce_n_s, rise, fall;
  logic [3:0] dio_s;

  psram_sck_sync u_sync (
    .clock  (clock),
    .reset  (reset),
    .sck_i  (qspi_sck),
    .ce_n_i (qspi_ce_n),
    .dio_i  (dio_in),
    .ce_n_o (ce_n_s),
    .dio_o  (dio_s),
    .rise_o (rise),
    .fall_o (fall)
  );

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [6:0]        sr_q, sr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              is_wr_q, is_wr_d;
  logic              nib_q, nib_d;
  logic [3:0]        wbuf_q, wbuf_d;
  logic              qpi_q, qpi_d;
  logic [3:0]        oe_q, oe_d;
  logic [3:0]        out_q, out_d;

  logic [7:0] cmd_byte;
  logic       mem_we;
  logic [7:0] mem_wdata, mem_rdata;
  logic [7:0] mem [0:(1 << ADDR_W) - 1];

  assign cmd_byte  = qpi_q ? {sr_q[3:0], dio_s} : {sr_q, dio_s[0]};
  assign mem_wdata = {wbuf_q, dio_s};
  assign mem_rdata = mem[addr_q];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    addr_d  = addr_q;
    is_wr_d = is_wr_q;
    nib_d   = nib_q;
    wbuf_d  = wbuf_q;
    qpi_d   = qpi_q;
    oe_d    = oe_q;
    out_d   = out_q;
    mem_we  = 1'b0;
    // Deselect wins over everything; a pending high nibble is simply dropped.
    if (ce_n_s) begin
      state_d = StIdle;
      oe_d    = 4'h0;
      cnt_d   = 8'd0;
      nib_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StCmd;
          cnt_d   = 8'd0;
        end
        StCmd: if (rise) begin
          sr_d  = cmd_byte[6:0];
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == (qpi_q ? 8'd1 : 8'd7)) begin
            cnt_d   = 8'd0;
            state_d = StSkip;
            case (cmd_byte)
              CMD_QREAD:  begin state_d = StAddr; is_wr_d = 1'b0; end
              CMD_QWRITE: begin state_d = StAddr; is_wr_d = 1'b1; end
              CMD_QPI_EN: qpi_d = 1'b1;
              CMD_QPI_EX: qpi_d = 1'b0;
              default: ;
            endcase
          end
        end
        StAddr: if (rise) begin
          addr_d = {addr_q[ADDR_W-5:0], dio_s};
          cnt_d  = cnt_q + 8'd1;
          if (cnt_q == AddrLast) begin
            cnt_d   = 8'd0;
            nib_d   = 1'b0;
            state_d = is_wr_q ? StWdata : StWait;
          end
        end
        StWait: if (rise) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == WaitLast) begin
            cnt_d   = 8'd0;
            nib_d   = 1'b0;
            state_d = StRdata;
          end
        end
        StRdata: if (fall) begin
          oe_d  = 4'hF;
          out_d = nib_q ? mem_rdata[3:0] : mem_rdata[7:4];
          nib_d = ~nib_q;
          if (nib_q) addr_d = addr_q + ADDR_W'(1);
        end
        StWdata: if (rise) begin
          nib_d = ~nib_q;
          if (!nib_q) begin
            wbuf_d = dio_s;
          end else begin
            mem_we = 1'b1;
            addr_d = addr_q + ADDR_W'(1);
          end
        end
        StSkip: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      sr_q    <= 7'd0;
      addr_q  <= '0;
      is_wr_q <= 1'b0;
      nib_q   <= 1'b0;
      wbuf_q  <= 4'h0;
      qpi_q   <= 1'b0;
      oe_q    <= 4'h0;
      out_q   <= 4'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      addr_q  <= addr_d;
      is_wr_q <= is_wr_d;
      nib_q   <= nib_d;
      wbuf_q  <= wbuf_d;
      qpi_q   <= qpi_d;
      oe_q    <= oe_d;
      out_q   <= out_d;
    end
  end

  // Array is not reset; reset only suppresses an in-flight byte write.
  always_ff @(posedge clock) begin
    if (mem_we && !reset) mem[addr_q] <= mem_wdata;
  end

  assign dio_out = out_q;
  assign dio_oe  = oe_q;
  assign qpi     = qpi_q;

endmodule

// File: tb/tb_psram_qspi_dev.sv
// Self-checking bench: table vectors, hand sequences and random bursts vs a byte-array model.
module tb_psram_qspi_dev;

  localparam int unsigned AW    = 22;
  localparam logic [23:0] AMASK = 24'h3FFFFF;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       qspi_sck = 1'b0;
  logic       qspi_ce_n = 1'b1;
  logic [3:0] dio_in = 4'h0;
  logic [3:0] dio_out, dio_oe;
  logic       qpi;

  psram_qspi_dev #(.ADDR_W(AW), .WAIT_CYC(6)) dut (
    .clock     (clock),
    .reset     (reset),
    .qspi_sck  (qspi_sck),
    .qspi_ce_n (qspi_ce_n),
    .dio_in    (dio_in),
    .dio_out   (dio_out),
    .dio_oe    (dio_oe),
    .qpi       (qpi)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        wr;
    logic [23:0] waddr;
    logic [23:0] raddr;
    int          n;
    logic [7:0]  d0, d1;
    logic [7:0]  e0, e1;
  } vec_t;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic        m_qpi  = 1'b0;
  logic [7:0]  mdl [int unsigned];
  logic [7:0]  wr_buf [8];
  logic [7:0]  rd_buf [8];
  logic [3:0]  last_q, last_oe, oe_seen;
  vec_t        vecs [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  // One sck period: low phase (drive dio, sample device), then high phase.
  task automatic sck_cyc(input logic [3:0] d);
    qspi_sck = 1'b0;
    dio_in   = d;
    repeat (2) @(negedge clock);
    last_q  = dio_out;
    last_oe = dio_oe;
    oe_seen = oe_seen | dio_oe;
    qspi_sck = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic txn_begin();
    qspi_sck  = 1'b0;
    qspi_ce_n = 1'b0;
    @(negedge clock);
  endtask

  task automatic txn_end();
    qspi_sck = 1'b0;
    repeat (2) @(negedge clock);
    qspi_ce_n = 1'b1;
    repeat (3) @(negedge clock);
  endtask

  task automatic send_cmd(input logic [7:0] c);
    if (m_qpi) begin
      sck_cyc(c[7:4]);
      sck_cyc(c[3:0]);
    end else begin
      for (int i = 7; i >= 0; i--) sck_cyc({3'b000, c[i]});
    end
  endtask

  task automatic send_addr(input logic [23:0] a);
    for (int i = 5; i >= 0; i--) sck_cyc(a[i*4 +: 4]);
  endtask

  task automatic do_mode(input logic [7:0] c);
    txn_begin();
    send_cmd(c);
    txn_end();
    if (c == 8'h35) m_qpi = 1'b1;
    else if (c == 8'hF5) m_qpi = 1'b0;
    chk("qpi flag", {31'd0, qpi}, {31'd0, m_qpi});
  endtask

  task automatic do_write(input logic [23:0] a, input int n);
    txn_begin();
    send_cmd(8'h38);
    send_addr(a);
    for (int i = 0; i < n; i++) begin
      sck_cyc(wr_buf[i][7:4]);
      sck_cyc(wr_buf[i][3:0]);
      mdl[32'((a + 24'(i)) & AMASK)] = wr_buf[i];
    end
    txn_end();
  endtask

  task automatic do_read(input logic [23:0] a, input int n);
    logic [3:0] hi;
    txn_begin();
    oe_seen = 4'h0;
    send_cmd(8'hEB);
    send_addr(a);
    repeat (6) sck_cyc(4'h0);
    chk("oe low in cmd/addr/wait", {28'd0, oe_seen}, 32'h0);
    for (int i = 0; i < n; i++) begin
      sck_cyc(4'h0);
      hi = last_q;
      if (i == 0) chk("oe high in rdata", {28'd0, last_oe}, 32'hF);
      sck_cyc(4'h0);
      rd_buf[i] = {hi, last_q};
    end
    txn_end();
  endtask

  task automatic read_check(input logic [23:0] a, input int n);
    do_read(a, n);
    for (int i = 0; i < n; i++)
      chk($sformatf("read @%06h", (a + 24'(i)) & AMASK), {24'd0, rd_buf[i]},
          {24'd0, mdl[32'((a + 24'(i)) & AMASK)]});
  endtask

  initial begin
    logic [23:0] ra;
    int          rn;

    vecs[0] = '{1'b1, 24'h3FFFFF, 24'h3FFFFF, 2, 8'h11, 8'h22, 8'h11, 8'h22};
    vecs[1] = '{1'b0, 24'h000000, 24'h000000, 1, 8'h00, 8'h00, 8'h22, 8'h00};
    vecs[2] = '{1'b1, 24'hC00040, 24'h000040, 2, 8'h5A, 8'hC3, 8'h5A, 8'hC3};
    vecs[3] = '{1'b1, 24'h401234, 24'h001234, 2, 8'hDE, 8'hAD, 8'hDE, 8'hAD};
    vecs[4] = '{1'b1, 24'h000100, 24'hC00100, 2, 8'h00, 8'hFF, 8'h00, 8'hFF};

    repeat (3) @(negedge clock);
    chk("reset qpi", {31'd0, qpi}, 32'h0);
    chk("reset dio_oe", {28'd0, dio_oe}, 32'h0);
    chk("reset dio_out", {28'd0, dio_out}, 32'h0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // SPI enter-QPI, then a QPI write burst
    do_mode(8'h35);
    wr_buf[0] = 8'hA5;
    wr_buf[1] = 8'h3C;
    do_write(24'h000010, 2);

    do_read(24'h000010, 2);
    chk("nibble 0", {28'd0, rd_buf[0][7:4]}, 32'hA);
    chk("nibble 1", {28'd0, rd_buf[0][3:0]}, 32'h5);
    chk("nibble 2", {28'd0, rd_buf[1][7:4]}, 32'h3);
    chk("nibble 3", {28'd0, rd_buf[1][3:0]}, 32'hC);

    for (int v = 0; v < 5; v++) begin
      if (vecs[v].wr) begin
        wr_buf[0] = vecs[v].d0;
        wr_buf[1] = vecs[v].d1;
        do_write(vecs[v].waddr, vecs[v].n);
      end
      do_read(vecs[v].raddr, vecs[v].n);
      chk($sformatf("vec%0d byte0", v), {24'd0, rd_buf[0]}, {24'd0, vecs[v].e0});
      if (vecs[v].n > 1)
        chk($sformatf("vec%0d byte1", v), {24'd0, rd_buf[1]}, {24'd0, vecs[v].e1});
    end

    // Write aborted after one nibble leaves the byte untouched
    wr_buf[0] = 8'h77;
    do_write(24'h000020, 1);
    txn_begin();
    send_cmd(8'h38);
    send_addr(24'h000020);
    sck_cyc(4'h1);
    txn_end();
    do_read(24'h000020, 1);
    chk("aborted write keeps byte", {24'd0, rd_buf[0]}, 32'h77);

    // Unknown command is ignored
    txn_begin();
    oe_seen = 4'h0;
    send_cmd(8'h9F);
    repeat (10) sck_cyc(4'($urandom));
    chk("oe low after unknown cmd", {28'd0, oe_seen}, 32'h0);
    txn_end();
    read_check(24'h000020, 1);
    read_check(24'h000010, 2);
    do_mode(8'hF5);

    for (int it = 0; it < 10; it++) begin
      if ($urandom_range(1) == 1) do_mode(m_qpi ? 8'hF5 : 8'h35);
      ra = 24'($urandom);
      rn = int'($urandom_range(4, 1));
      for (int i = 0; i < rn; i++) wr_buf[i] = 8'($urandom);
      do_write(ra, rn);
      read_check(ra, rn);
    end

    // Reset in the middle of a QPI read burst
    if (!m_qpi) do_mode(8'h35);
    txn_begin();
    send_cmd(8'hEB);
    send_addr(24'h000010);
    repeat (6) sck_cyc(4'h0);
    sck_cyc(4'h0);
    chk("oe before reset", {28'd0, last_oe}, 32'hF);
    sck_cyc(4'h0);
    qspi_sck = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    chk("oe after reset", {28'd0, dio_oe}, 32'h0);
    chk("qpi after reset", {31'd0, qpi}, 32'h0);
    qspi_ce_n = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    m_qpi = 1'b0;
    read_check(24'h000010, 2);
    do_mode(8'h35);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "timeout");
  end

endmodule
